// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic-array drain-side blocks.
package tpu_pkg;

    localparam int LANE_W    = 8;
    localparam int DEFAULT_N = 8;

    typedef logic [LANE_W-1:0] lane_t;

    // Width of a lane index for an n-lane block (at least one bit).
    function automatic int lane_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int LANE_IDX_W = lane_idx_w(DEFAULT_N);

endpackage : tpu_pkg

// File: rtl/lane_merge_rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr with wrap
// and grants the first requester. The pointer register lives in the parent.
module rr_arbiter
    import tpu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]               req,
    input  logic [lane_idx_w(N)-1:0]   ptr,
    input  logic                       enable,
    output logic [N-1:0]               gnt,
    output logic [lane_idx_w(N)-1:0]   gnt_idx,
    output logic                       gnt_any
);

    localparam int IW = lane_idx_w(N);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Walk lanes ptr, ptr+1, ... with explicit modulo-N wrap; first hit wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < N; off++) begin
            cand     = (int'(ptr) + off) % N;
            cand_idx = IW'(cand);
            if (!gnt_any && req[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
                if (enable) begin
                    gnt[cand_idx] = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/lane_merge_rr.sv
// N-to-1 lane merge with fair round-robin arbitration into a single
// registered valid/ready stream tagged with the source lane index.
module lane_merge_rr
    import tpu_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             in_data [N],
    input  logic [N-1:0]             in_valid,
    output logic [N-1:0]             in_ready,
    output logic [W-1:0]             out_data,
    output logic [lane_idx_w(N)-1:0] out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int IW = lane_idx_w(N);

    logic [IW-1:0] ptr;
    logic          load_en;
    logic          arb_enable;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;

    // The output register can take a new beat when empty or draining this
    // cycle; out_ready reaches in_ready combinationally through this term.
    // Reset also holds every in_ready low.
    assign load_en    = !out_valid || out_ready;
    assign arb_enable = load_en && !rst;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .enable  (arb_enable),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign in_ready = gnt;

    // Output register and round-robin pointer; the pointer moves just past
    // the granted lane and wraps explicitly so N need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[gnt_idx];
                out_sel   <= gnt_idx;
                ptr       <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : lane_merge_rr

// File: tb/tb_lane_merge_rr.sv
// Self-checking bench for lane_merge_rr: directed table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_lane_merge_rr;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_sel;
    logic          out_valid;
    logic          out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;

    typedef struct {
        logic [N-1:0] vld;
        logic         rdy;
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        int           exp_sel;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    lane_merge_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] vld, input logic rdy);
        in_valid  = vld;
        out_ready = rdy;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setRampData();
        for (int i = 0; i < N; i++) in_data[i] = W'(8'h10 + i);
    endtask

    // Priority order starts at the pointer and wraps; first valid lane wins.
    function automatic int modelGrant(input logic [N-1:0] v, input int p);
        int order[$];
        for (int i = p; i < N; i++) order.push_back(i);
        for (int i = 0; i < p; i++) order.push_back(i);
        foreach (order[k]) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic logic [N-1:0] modelReady(input logic [N-1:0] v, input logic rdy);
        int g;
        if (m_valid && !rdy) return '0;
        g = modelGrant(v, m_ptr);
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic modelClock(input logic [N-1:0] v, input logic rdy);
        int g;
        if (!m_valid || rdy) begin
            g = modelGrant(v, m_ptr);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g];
                m_sel   = g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [N-1:0] pending;
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic [31:0]  rnd;
        logic         r;

        // Reset with every lane requesting
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        setRampData();
        @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data",  32'(out_data),  32'd0);
        checkOutput("reset out_sel",   32'(out_sel),   32'd0);
        checkOutput("reset in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        modelReset();

        // All lanes valid: strict rotation, one beat per cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus('1, 1'b1);
            checkOutput("all in_ready", 32'(in_ready), 32'(N'(1) << (i % N)));
            clockEdge();
            checkOutput("all out_valid", 32'(out_valid), 32'd1);
            checkOutput("all out_sel",   32'(out_sel),   32'(i % N));
            checkOutput("all out_data",  32'(out_data),  32'(8'h10 + (i % N)));
        end

        // Directed table: sparse lanes, wrap, backpressure, drain
        vecs[0]  = '{8'h24, 1'b1, 8'h04, 1'b1, 2, 8'h12};
        vecs[1]  = '{8'h24, 1'b1, 8'h20, 1'b1, 5, 8'h15};
        vecs[2]  = '{8'h24, 1'b1, 8'h04, 1'b1, 2, 8'h12};
        vecs[3]  = '{8'h24, 1'b1, 8'h20, 1'b1, 5, 8'h15};
        vecs[4]  = '{8'h00, 1'b1, 8'h00, 1'b0, 5, 8'h15};
        vecs[5]  = '{8'h80, 1'b1, 8'h80, 1'b1, 7, 8'h17};
        vecs[6]  = '{8'h01, 1'b1, 8'h01, 1'b1, 0, 8'h10};
        vecs[7]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 0, 8'h10};
        vecs[8]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 0, 8'h10};
        vecs[9]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 0, 8'h10};
        vecs[10] = '{8'hFF, 1'b1, 8'h02, 1'b1, 1, 8'h11};
        vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b1, 1, 8'h11};
        vecs[12] = '{8'h00, 1'b1, 8'h00, 1'b0, 1, 8'h11};
        resetDut();
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].vld, vecs[k].rdy);
            checkOutput($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
            clockEdge();
            checkOutput($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d out_sel", k),   32'(out_sel),   32'(vecs[k].exp_sel));
            checkOutput($sformatf("vec%0d out_data", k),  32'(out_data),  32'(vecs[k].exp_data));
        end

        // Reset mid-stream while lane 3's beat sits in the output register
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus('1, 1'b1);
            clockEdge();
        end
        checkOutput("mid pre out_sel",   32'(out_sel),   32'd3);
        checkOutput("mid pre out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid async out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid async in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus('1, 1'b1);
        checkOutput("mid restart in_ready", 32'(in_ready), 32'h01);
        clockEdge();
        checkOutput("mid restart out_sel", 32'(out_sel), 32'd0);

        // Randomized traffic against the model; producers hold valid and data
        resetDut();
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            rnd = $urandom();
            v   = pending | rnd[N-1:0];
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) begin
                    rnd        = $urandom();
                    in_data[i] = rnd[W-1:0];
                end
            end
            r = ($urandom_range(0, 3) != 0);
            applyStimulus(v, r);
            exp_rdy = modelReady(v, r);
            checkOutput("rand in_ready", 32'(in_ready), 32'(exp_rdy));
            pending = v & ~exp_rdy;
            modelClock(v, r);
            clockEdge();
            checkOutput("rand out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("rand out_sel",   32'(out_sel),   32'(m_sel));
            checkOutput("rand out_data",  32'(out_data),  32'(m_data));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_lane_merge_rr
